imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
- Parametrised, registered successor to the decode-stage immediate extender.
- Extracts and extends immediates for all RV32/RV64 base formats: I, S, B, J, U and CSR zimm.
- Adds an illegal-format flag and a 1-cycle pipelined valid/ready interface with a 2-entry skid buffer, so the decode→execute boundary can stall or flush without losing or duplicating immediates.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64. Sign/zero extension fills to XLEN.
- TAG_W, 5, width of an opaque sideband tag (e.g. rd or ROB index) carried alongside each immediate.

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered entries (branch mispredict / trap)
- in_valid  in  1  instr/immsrc/in_tag valid this cycle
- in_ready  out  1  block can accept an input this cycle
- instr  in  25  instruction bits [31:7]
- immsrc  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR zimm), 110/111 illegal
- in_tag  in  TAG_W  sideband tag, returned unchanged
- out_valid  out  1  immext/out_tag/fmt_err valid
- out_ready  in  1  consumer accepts output this cycle
- immext  out  XLEN  extended immediate
- out_tag  out  TAG_W  tag of the output entry
- fmt_err  out  1  output entry had an illegal immsrc

Behaviour:
- Reset is synchronous: on a clk edge with reset=1, out_valid=0, immext=0, out_tag=0, fmt_err=0, skid empty, in_ready=1.
  - Inputs presented while reset=1 are dropped.
- Extension, with s = instr[31] replicated to fill XLEN:
  - I: {s, instr[31:20]}
  - S: {s, instr[31:25], instr[11:7]}
  - B: {s, instr[7], instr[30:25], instr[11:8], 0}
  - J: {s, instr[19:12], instr[20], instr[30:21], 0}
  - U: {s, instr[31:12], 12'b0}; sign-extended for XLEN=64.
  - Z: zero-extend instr[19:15].
  - 110/111: immext=0, fmt_err=1. fmt_err=0 for every legal format.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Transfer occurs when out_valid && out_ready.
- Storage is an output register (main) plus one skid register. in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
- Latency: an input accepted in cycle N appears on the outputs in cycle N+1 if main is empty or transferring in cycle N.
- Per-cycle update, evaluated in this priority order:
  1. reset.
  2. flush: main and skid invalidated. An input accepted in the same cycle is dropped. in_ready=1 next cycle.
  3. Main empty or transferring: main loads from skid if skid is valid (skid empties; a simultaneous accept lands in skid), else main loads the accepted input, else main goes invalid.
  4. Main full and not transferring: an accepted input goes to skid; in_ready=0 next cycle.
- Ordering is strictly FIFO; no entry is ever duplicated or dropped except by flush/reset.
- out_valid holds, and immext/out_tag/fmt_err stay stable, while out_valid && !out_ready.
- Reset or flush mid-stall clears both entries regardless of out_ready.

Test Plan:
- XLEN=32, out_ready=1, single accepts:
  - 0xFFF00093 (I) -> 0xFFFFFFFF
  - 0xFE112E23 (S) -> 0xFFFFFFFC
  - 0xFFDFF06F (J) -> 0xFFFFFFFC
  - 0x123452B7 (U) -> 0x12345000
  - Each appears 1 cycle after accept with fmt_err=0.
- Z and illegal formats:
  - Z with instr[19:15]=5'b11111 -> 0x0000001F.
  - immsrc=3'b110 -> immext=0, fmt_err=1, tag preserved.
- Backpressure:
  - Hold out_ready=0, offer tags 1,2,3 back-to-back.
  - Required: tags 1 and 2 accepted, in_ready=0 from cycle after the second accept, outputs stable.
  - Then raise out_ready: outputs 1,2,3 in order, no gaps after the first, no duplicates.
- Flush:
  - With main and skid full, assert flush together with in_valid (tag 9).
  - Next cycle out_valid=0, in_ready=1; tag 9 never appears at the output.
- Reset mid-stall:
  - With both entries full and out_ready=0, assert reset for one cycle.
  - Next cycle out_valid=0, immext=0, fmt_err=0, in_ready=1.
- XLEN=64:
  - U-format 0x800002B7 -> 0xFFFFFFFF80000000.
  - B-format with instr[31]=1 sign-extends across all 64 bits.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered RV32/RV64 immediate extender with a 2-entry skid buffer on a valid/ready interface
module imm_extend_pipe #(
  parameter int XLEN = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immext,
  output logic [TAG_W-1:0] out_tag,
  output logic             fmt_err
);
  logic [XLEN-1:0]  ext;
  logic             ext_err;
  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_err;
  logic             accept;
  assign accept = in_valid && in_ready;
  assign in_ready = !skid_valid;
  // Decode the immediate; signed casts replicate instr[31] up to XLEN
  always_comb begin
    ext_err = immsrc[2:1] == 2'b11;
    ext = immsrc == 3'd0 ? XLEN'($signed(instr[31:20])) :
          immsrc == 3'd1 ? XLEN'($signed({instr[31:25], instr[11:7]})) :
          immsrc == 3'd2 ? XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})) :
          immsrc == 3'd3 ? XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})) :
          immsrc == 3'd4 ? XLEN'($signed({instr[31:12], 12'h000})) :
          immsrc == 3'd5 ? XLEN'(instr[19:15]) : '0;
  end
  // Main output register refills from skid first so ordering stays FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      immext <= '0;
      out_tag <= '0;
      fmt_err <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm <= '0;
      skid_tag <= '0;
      skid_err <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid <= 1'b1;
        immext <= skid_imm;
        out_tag <= skid_tag;
        fmt_err <= skid_err;
        skid_valid <= accept;
        if (accept) begin
          skid_imm <= ext;
          skid_tag <= in_tag;
          skid_err <= ext_err;
        end
      end else begin
        out_valid <= accept;
        if (accept) begin
          immext <= ext;
          out_tag <= in_tag;
          fmt_err <= ext_err;
        end
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_imm <= ext;
      skid_tag <= in_tag;
      skid_err <= ext_err;
    end
  end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed plus random checks of both XLEN variants against a FIFO reference model
module tb_imm_extend_pipe;
  localparam int TW = 5;
  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [31:7] instr;
  logic [2:0] immsrc;
  logic [TW-1:0] in_tag;
  logic in_ready32, out_valid32, fmt_err32;
  logic [31:0] immext32;
  logic [TW-1:0] out_tag32;
  logic in_ready64, out_valid64, fmt_err64;
  logic [63:0] immext64;
  logic [TW-1:0] out_tag64;
  typedef struct {
    logic [63:0] imm;
    logic [TW-1:0] tag;
    logic err;
  } ent_t;
  ent_t q[$];
  int checks = 0;
  int errors = 0;
  bit acc;
  bit done;
  always #5 clk = ~clk;
  imm_extend_pipe #(.XLEN(32), .TAG_W(TW)) d32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .immext(immext32), .out_tag(out_tag32), .fmt_err(fmt_err32));
  imm_extend_pipe #(.XLEN(64), .TAG_W(TW)) d64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .immext(immext64), .out_tag(out_tag64), .fmt_err(fmt_err64));
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] src);
    logic signed [11:0] a;
    logic signed [12:0] b;
    logic signed [20:0] j;
    logic signed [31:0] u;
    a = (src == 3'd1) ? {i[31:25], i[11:7]} : i[31:20];
    b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    u = {i[31:12], 12'h000};
    case (src)
      3'd0, 3'd1: return longint'(a);
      3'd2: return longint'(b);
      3'd3: return longint'(j);
      3'd4: return longint'(u);
      3'd5: return {59'd0, i[19:15]};
      default: return 64'd0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input bit rst);
    chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
    chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
    chk("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
    chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("immext32", 64'(immext32), 64'(q[0].imm[31:0]));
      chk("immext64", immext64, q[0].imm);
      chk("out_tag32", 64'(out_tag32), 64'(q[0].tag));
      chk("out_tag64", 64'(out_tag64), 64'(q[0].tag));
      chk("fmt_err32", 64'(fmt_err32), 64'(q[0].err));
      chk("fmt_err64", 64'(fmt_err64), 64'(q[0].err));
    end
    if (rst) begin
      chk("rst_immext32", 64'(immext32), 64'd0);
      chk("rst_immext64", immext64, 64'd0);
      chk("rst_tag32", 64'(out_tag32), 64'd0);
      chk("rst_tag64", 64'(out_tag64), 64'd0);
      chk("rst_err32", 64'(fmt_err32), 64'd0);
      chk("rst_err64", 64'(fmt_err64), 64'd0);
    end
  endtask
  task automatic step(input bit rst, input bit fl, input bit iv, input logic [31:0] ins,
                      input logic [2:0] src, input logic [TW-1:0] tg, input bit ordy);
    ent_t e;
    reset = rst;
    flush = fl;
    in_valid = iv;
    instr = ins[31:7];
    immsrc = src;
    in_tag = tg;
    out_ready = ordy;
    @(posedge clk);
    acc = iv && q.size() < 2 && !rst && !fl;
    if (rst || fl) q.delete();
    else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) begin
        e.imm = ref_imm(ins, src);
        e.tag = tg;
        e.err = src[2:1] == 2'b11;
        q.push_back(e);
      end
    end
    @(negedge clk);
    check_all(rst);
  endtask
  initial begin
    step(1, 0, 1, 32'hFFF00093, 3'd0, 5'd4, 1);
    step(1, 0, 0, 32'h0, 3'd0, 5'd0, 1);
    step(0, 0, 1, 32'hFFF00093, 3'd0, 5'd1, 1);
    step(0, 0, 1, 32'hFE112E23, 3'd1, 5'd2, 1);
    step(0, 0, 1, 32'hFFDFF06F, 3'd3, 5'd3, 1);
    step(0, 0, 1, 32'h123452B7, 3'd4, 5'd4, 1);
    step(0, 0, 1, 32'h000F8073, 3'd5, 5'd5, 1);
    step(0, 0, 1, 32'hFFFFFFFF, 3'd6, 5'd6, 1);
    step(0, 0, 1, 32'hABCDEF12, 3'd7, 5'd7, 1);
    step(0, 0, 1, 32'h800002B7, 3'd4, 5'd8, 1);
    step(0, 0, 1, 32'hFE000EE3, 3'd2, 5'd10, 1);
    step(0, 0, 0, 32'h0, 3'd0, 5'd0, 1);
    step(0, 0, 1, 32'h00100093, 3'd0, 5'd1, 0);
    step(0, 0, 1, 32'h00200093, 3'd0, 5'd2, 0);
    step(0, 0, 1, 32'h00300093, 3'd0, 5'd3, 0);
    step(0, 0, 1, 32'h00300093, 3'd0, 5'd3, 0);
    done = 0;
    for (int k = 0; k < 4 && !done; k++) begin
      step(0, 0, 1, 32'h00300093, 3'd0, 5'd3, 1);
      done = acc;
    end
    chk("tag3_accepted", 64'(done), 64'd1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 32'h0, 3'd0, 5'd0, 1);
    step(0, 0, 1, 32'hFFF00093, 3'd0, 5'd11, 0);
    step(0, 0, 1, 32'hFE112E23, 3'd1, 5'd12, 0);
    step(0, 1, 1, 32'hFFDFF06F, 3'd3, 5'd9, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 32'h0, 3'd0, 5'd0, 1);
    step(0, 0, 1, 32'hFFF00093, 3'd0, 5'd13, 0);
    step(0, 0, 1, 32'hFFFFFFFF, 3'd6, 5'd14, 0);
    step(1, 0, 1, 32'hFFDFF06F, 3'd3, 5'd15, 0);
    step(0, 0, 0, 32'h0, 3'd0, 5'd0, 1);
    for (int k = 0; k < 600; k++) begin
      int r;
      r = $urandom_range(0, 255);
      step(r == 0, r > 0 && r < 6, $urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
           TW'($urandom), $urandom_range(0, 3) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
